// File: rtl/control_unit.sv
// rtl/control_unit.sv - Hardwired sequencer for a 16-bit accumulator-less CPU datapath
//
// Purpose
//   Sequences each instruction through FETCH_L, FETCH_H, EXEC and an optional
//   EXEC2 cycle. It drives every register-file, address-register-file, ALU,
//   IR, memory and mux select of the datapath. The state is registered. All
//   outputs are combinational from the state and IROut.
//
// Optional feature
//   CU_FLAG_BRANCH_EN : when defined, opcode 0xD (BNE) loads PC from imm if the
//                       Z flag (ALUOutFlag[3]) is clear. When undefined, 0xD is
//                       a NOP.
//
// Ports
//   Clock        in  1   rising-edge clock
//   Reset        in  1   asynchronous, active-high; forces FETCH_L and idle outputs
//   IROut        in  16  instruction word {opcode[15:12], Rd[11:10], Rs[9:8], imm[7:0]}
//   ALUOutFlag   in  4   {Z,C,N,O}
//   RF_OutASel   out 2   register file A-port select
//   RF_OutBSel   out 2   register file B-port select
//   RF_FunSel    out 2   00 clear, 01 load, 10 decrement, 11 increment
//   RF_RegSel    out 4   bit3=R1 .. bit0=R4, active-low
//   ALU_FunSel   out 4   ALU operation
//   ARF_OutCSel  out 2   ARF C-port select
//   ARF_OutDSel  out 2   ARF D-port (memory address) select, 00=PC 01=AR
//   ARF_FunSel   out 2   same encoding as RF_FunSel
//   ARF_RegSel   out 3   {PC,AR,SP}, active-low
//   IR_LH        out 1   0 = load low byte, 1 = load high byte
//   IR_Enable    out 1   IR write enable
//   IR_Funsel    out 2   IR function
//   Mem_WR       out 1   1 = write
//   Mem_CS       out 1   0 = memory selected
//   MuxASel      out 2   00 IR[7:0], 01 MemoryOut, 11 ALUOut
//   MuxBSel      out 2   01 IR[7:0]
//   MuxCSel      out 1   0 = RF AOut
//   SeqCnt       out 3   current state
//   Halted       out 1   processor halted

module control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  ALUOutFlag,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  SeqCnt,
  output logic        Halted
);

  typedef enum logic [2:0] {
    FETCH_L = 3'd0,
    FETCH_H = 3'd1,
    EXEC    = 3'd2,
    EXEC2   = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_LDM  = 4'h1;
  localparam logic [3:0] OP_STM  = 4'h2;
  localparam logic [3:0] OP_ALU  = 4'h4;
  localparam logic [3:0] OP_BRA  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] FUN_LOAD = 2'b01;
  localparam logic [1:0] FUN_INC  = 2'b11;

  // Active-low one-hot selects for the address register file {PC,AR,SP}
  localparam logic [2:0] ARF_SEL_PC   = 3'b011;
  localparam logic [2:0] ARF_SEL_AR   = 3'b101;
  localparam logic [2:0] ARF_SEL_NONE = 3'b111;

  state_t r_state;
  state_t w_next;

  logic [3:0] w_opcode;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic [7:0] w_imm;
  logic [3:0] w_rd_sel;
  logic       w_bne_taken;

  assign w_opcode = IROut[15:12];
  assign w_rd     = IROut[11:10];
  assign w_rs     = IROut[9:8];
  assign w_imm    = IROut[7:0];

  // Rd=0 addresses R1, which sits in bit 3, so the cleared bit walks down
  // from the MSB as Rd increases.
  assign w_rd_sel = ~(4'b1000 >> w_rd);

`ifdef CU_FLAG_BRANCH_EN
  assign w_bne_taken = ~ALUOutFlag[3];
`else
  assign w_bne_taken = 1'b0;
`endif

  // Only Z can steer the sequencer; the remaining flags are intentionally
  // ignored.
  logic w_unused_flags;
  assign w_unused_flags = &{1'b0, ALUOutFlag};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= FETCH_L;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    // Idle defaults; each state overrides only what it uses.
    w_next      = r_state;
    RF_OutASel  = 2'b00;
    RF_OutBSel  = 2'b00;
    RF_FunSel   = 2'b00;
    RF_RegSel   = 4'b1111;
    ALU_FunSel  = 4'b0000;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = ARF_SEL_NONE;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = 2'b00;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;

    // Reset must idle the datapath in the same cycle it is raised, not after
    // the next edge, so the decode is bypassed rather than relying on the flop.
    if (!Reset) begin
      unique case (r_state)
        FETCH_L, FETCH_H: begin
          // Read M[PC] into one IR byte and post-increment PC.
          Mem_CS      = 1'b0;
          Mem_WR      = 1'b0;
          ARF_OutDSel = 2'b00;
          IR_Enable   = 1'b1;
          IR_LH       = (r_state == FETCH_H);
          IR_Funsel   = FUN_LOAD;
          ARF_RegSel  = ARF_SEL_PC;
          ARF_FunSel  = FUN_INC;
          w_next      = (r_state == FETCH_L) ? FETCH_H : EXEC;
        end

        EXEC: begin
          w_next = FETCH_L;
          case (w_opcode)
            OP_LDI: begin
              MuxASel   = 2'b00;
              RF_FunSel = FUN_LOAD;
              RF_RegSel = w_rd_sel;
            end
            OP_LDM, OP_STM: begin
              // Both memory ops first latch the address into AR.
              MuxBSel    = 2'b01;
              ARF_RegSel = ARF_SEL_AR;
              ARF_FunSel = FUN_LOAD;
              w_next     = EXEC2;
            end
            OP_ALU: begin
              RF_OutASel = w_rs;
              RF_OutBSel = w_rd;
              ALU_FunSel = w_imm[7:4];
              MuxCSel    = 1'b0;
              MuxASel    = 2'b11;
              RF_FunSel  = FUN_LOAD;
              RF_RegSel  = w_rd_sel;
            end
            OP_BRA: begin
              MuxBSel    = 2'b01;
              ARF_RegSel = ARF_SEL_PC;
              ARF_FunSel = FUN_LOAD;
            end
            OP_BNE: begin
              if (w_bne_taken) begin
                MuxBSel    = 2'b01;
                ARF_RegSel = ARF_SEL_PC;
                ARF_FunSel = FUN_LOAD;
              end
            end
            OP_HALT: begin
              w_next = HALT;
            end
            default: begin
              // Unassigned opcodes retire as NOPs.
            end
          endcase
        end

        EXEC2: begin
          w_next      = FETCH_L;
          ARF_OutDSel = 2'b01;
          Mem_CS      = 1'b0;
          if (w_opcode == OP_STM) begin
            // Rs reaches memory through the ALU pass-through on RF AOut.
            RF_OutASel = w_rs;
            MuxCSel    = 1'b0;
            ALU_FunSel = 4'b0000;
            Mem_WR     = 1'b1;
          end else begin
            MuxASel   = 2'b01;
            RF_FunSel = FUN_LOAD;
            RF_RegSel = w_rd_sel;
          end
        end

        HALT: begin
          w_next = HALT;
        end

        default: begin
          w_next = FETCH_L;
        end
      endcase
    end
  end

  assign SeqCnt = Reset ? 3'd0 : r_state;
  assign Halted = ~Reset & (r_state == HALT);

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - Self-checking bench for control_unit against a cycle-level instruction model

module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  SeqCnt;
  logic        Halted;

  int n_cmp  = 0;
  int n_fail = 0;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
    .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .MuxCSel(MuxCSel), .SeqCnt(SeqCnt), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [1:0] rf_a;
    logic [1:0] rf_b;
    logic [1:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] alu_fun;
    logic [1:0] arf_c;
    logic [1:0] arf_d;
    logic [1:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_fun;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic [2:0] seq;
    logic       halted;
  } outs_t;

`ifdef CU_FLAG_BRANCH_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  function automatic outs_t idle(input logic [2:0] seq, input logic halted);
    outs_t o;
    o        = '0;
    o.rf_reg = 4'b1111;
    o.arf_reg = 3'b111;
    o.mem_cs = 1'b1;
    o.seq    = seq;
    o.halted = halted;
    return o;
  endfunction

  // Cycles an instruction occupies before the next fetch begins.
  function automatic int latency(input logic [15:0] ir);
    return (ir[15:12] == 4'h1 || ir[15:12] == 4'h2) ? 4 : 3;
  endfunction

  // What the datapath must be told during cycle 'cyc' (0 = first fetch byte)
  // of instruction 'ir', given the current Z flag.
  function automatic outs_t expect_cycle(input logic [15:0] ir, input int cyc, input bit z);
    outs_t      o;
    logic [3:0] op;
    int         rd;
    logic [3:0] rd_mask;
    op      = ir[15:12];
    rd      = int'(ir[11:10]);
    rd_mask = 4'b1111;
    rd_mask[3 - rd] = 1'b0;
    o = idle(3'(cyc), 1'b0);
    if (cyc < 2) begin
      o.mem_cs  = 1'b0;
      o.ir_en   = 1'b1;
      o.ir_lh   = (cyc == 1);
      o.ir_fun  = 2'b01;
      o.arf_reg = 3'b011;
      o.arf_fun = 2'b11;
    end else if (cyc == 2) begin
      if (op == 4'h0) begin
        o.mux_a  = 2'b00;
        o.rf_fun = 2'b01;
        o.rf_reg = rd_mask;
      end else if (op == 4'h1 || op == 4'h2) begin
        o.mux_b   = 2'b01;
        o.arf_reg = 3'b101;
        o.arf_fun = 2'b01;
      end else if (op == 4'h4) begin
        o.rf_a    = ir[9:8];
        o.rf_b    = ir[11:10];
        o.alu_fun = ir[7:4];
        o.mux_a   = 2'b11;
        o.rf_fun  = 2'b01;
        o.rf_reg  = rd_mask;
      end else if (op == 4'hC || (op == 4'hD && BNE_EN && !z)) begin
        o.mux_b   = 2'b01;
        o.arf_reg = 3'b011;
        o.arf_fun = 2'b01;
      end
    end else begin
      o.arf_d  = 2'b01;
      o.mem_cs = 1'b0;
      if (op == 4'h2) begin
        o.rf_a   = ir[9:8];
        o.mem_wr = 1'b1;
      end else begin
        o.mux_a  = 2'b01;
        o.rf_fun = 2'b01;
        o.rf_reg = rd_mask;
      end
    end
    return o;
  endfunction

  task automatic check(input string tag, input outs_t exp);
    outs_t act;
    act = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel, ARF_OutCSel,
           ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable, IR_Funsel,
           Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel, SeqCnt, Halted};
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, act, exp);
    end
  endtask

  // Runs one instruction starting in its first fetch cycle, checking every
  // cycle. abort_cyc >= 0 raises Reset partway through that cycle.
  task automatic run_instr(input logic [15:0] ir, input bit z, input int abort_cyc);
    IROut      = ir;
    ALUOutFlag = {z, 3'($urandom_range(0, 7))};
    for (int cyc = 0; cyc < latency(ir); cyc++) begin
      #1;
      check($sformatf("ir%04h_c%0d", ir, cyc), expect_cycle(ir, cyc, z));
      if (cyc == abort_cyc) begin
        #1 Reset = 1'b1;
        #1 check($sformatf("ir%04h_rst_now", ir), idle(3'd0, 1'b0));
        @(negedge Clock);
        #1 check($sformatf("ir%04h_rst_held", ir), idle(3'd0, 1'b0));
        Reset = 1'b0;
        return;
      end
      @(negedge Clock);
    end
  endtask

  initial begin
    logic [3:0] ops [10];
    logic [15:0] ir;
    ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'hC, 4'hD, 4'h3, 4'h5, 4'hA, 4'hE};

    Reset      = 1'b1;
    IROut      = 16'(($urandom));
    ALUOutFlag = 4'h0;
    repeat (2) @(negedge Clock);
    #1 check("reset_idle", idle(3'd0, 1'b0));
    @(negedge Clock);
    Reset = 1'b0;

    run_instr(16'h0E55, 1'b0, -1);
    run_instr(16'h1C20, 1'b0, -1);
    run_instr(16'h2130, 1'b1, -1);
    run_instr(16'h46A3, 1'b0, -1);
    run_instr(16'hC0AB, 1'b1, -1);
    run_instr(16'hD040, 1'b0, -1);
    run_instr(16'hD040, 1'b1, -1);
    run_instr(16'h7123, 1'b0, -1);
    run_instr(16'h1845, 1'b0, 3);
    run_instr(16'h0312, 1'b0, -1);

    for (int n = 0; n < 150; n++) begin
      ir = {ops[$urandom_range(0, 9)], 12'($urandom)};
      run_instr(ir, 1'($urandom), ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1);
    end

    run_instr(16'hF000, 1'b0, -1);
    for (int k = 0; k < 10; k++) begin
      IROut = 16'($urandom);
      #1 check($sformatf("halt_hold%0d", k), idle(3'd4, 1'b1));
      @(negedge Clock);
    end
    Reset = 1'b1;
    #1 check("halt_reset", idle(3'd0, 1'b0));
    @(negedge Clock);
    Reset = 1'b0;
    run_instr(16'h0B77, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
